// File: rtl/sample_reader_pkg.sv
// sample_reader_pkg: shared types and constants for the sample ring-buffer reader.
`timescale 1ns/1ps
package sample_reader_pkg;
    localparam int PTR_W = 12;
    localparam int WORD_W = 10;
    localparam int LEVEL_MAX = 2048;
    localparam logic [13:0] OFS_POP = 14'h0000;
    localparam logic [13:0] OFS_STATUS = 14'h0004;
    localparam logic [13:0] OFS_RDPTR = 14'h0008;
    localparam logic [13:0] OFS_THRESH = 14'h000C;
    typedef enum logic [1:0] {ST_IDLE, ST_MEM, ST_CAP, ST_ACK} state_t;
endpackage

// File: rtl/sample_sram_rdport.sv
// sample_sram_rdport: one-cycle chip select on SRAM port 1, bank data selected two cycles after the request.
`timescale 1ns/1ps
module sample_sram_rdport
    import sample_reader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              bank,
    input  logic [WORD_W-1:0] word,
    input  logic [31:0]       mem_data0_i,
    input  logic [31:0]       mem_data1_i,
    output logic [1:0]        mem_renb_o,
    output logic [WORD_W-1:0] mem_raddr_o,
    output logic [31:0]       rd_data,
    output logic              rd_valid
);
    logic bank_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_renb_o <= 2'b11;
            mem_raddr_o <= '0;
            bank_q <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            mem_renb_o <= req ? (bank ? 2'b01 : 2'b10) : 2'b11;
            mem_raddr_o <= req ? word : mem_raddr_o;
            bank_q <= req ? bank : bank_q;
            rd_valid <= ~&mem_renb_o;
        end
    end

    // dout1 is valid the cycle after csb1, so the bank choice is held one cycle
    assign rd_data = bank_q ? mem_data1_i : mem_data0_i;
endmodule

// File: rtl/sample_buf_reader.sv
// sample_buf_reader: Wishbone consumer of the ADC sample ring buffer (read pointer, level, threshold irq).
// SAMPLE_READER_WINDOW_EN enables the random-access SRAM window at adr[13]=1.
`timescale 1ns/1ps
module sample_buf_reader
    import sample_reader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    input  logic [PTR_W-1:0]  wr_ptr_i,
    output logic [PTR_W-1:0]  rd_ptr_o,
    output logic [1:0]        mem_renb_o,
    output logic [WORD_W-1:0] mem_raddr_o,
    input  logic [31:0]       mem_data0_i,
    input  logic [31:0]       mem_data1_i,
    output logic              empty_o,
    output logic              irq_o
);
    state_t state_q, state_d;
    logic [PTR_W-1:0] rd_ptr, thresh, level;
    logic [WORD_W-1:0] req_word;
    logic [31:0] reg_rdata, rd_data;
    logic [13:0] ofs;
    logic underflow, pop_pend, irq_q, hit, accept, pop_rd, win_rd, empty;
    logic mem_req, pop_start, req_bank, rd_valid, unused_ok;

    assign ofs = wbs_adr_i[13:0];
    assign hit = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:14] == BASE_ADDR[31:14]);
    assign accept = state_q == ST_IDLE && hit;
    assign level = wr_ptr_i - rd_ptr;
    assign empty = level == '0;
    assign pop_rd = !wbs_we_i && ofs == OFS_POP;
`ifdef SAMPLE_READER_WINDOW_EN
    assign win_rd = !wbs_we_i && ofs[13];
`else
    assign win_rd = 1'b0;
`endif
    assign req_bank = win_rd ? wbs_adr_i[12] : rd_ptr[10];
    assign req_word = win_rd ? wbs_adr_i[11:2] : rd_ptr[WORD_W-1:0];
    assign reg_rdata = wbs_we_i ? '0 :
                       ofs == OFS_STATUS ? {18'b0, underflow, empty, level} :
                       ofs == OFS_RDPTR ? {20'b0, rd_ptr} :
                       ofs == OFS_THRESH ? {20'b0, thresh} : '0;
    assign unused_ok = ^{wbs_sel_i, wbs_dat_i[31:PTR_W]};

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) state_q <= ST_IDLE;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        mem_req = 1'b0;
        pop_start = 1'b0;
        case (state_q)
            ST_IDLE: if (hit) begin
                pop_start = pop_rd && !empty;
                mem_req = win_rd || pop_start;
                state_d = mem_req ? ST_MEM : ST_ACK;
            end
            ST_MEM: state_d = ST_CAP;
            ST_CAP: state_d = rd_valid ? ST_ACK : ST_CAP;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            wbs_dat_o <= '0;
            rd_ptr <= '0;
            thresh <= '0;
            underflow <= 1'b0;
            pop_pend <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            if (accept) begin
                wbs_dat_o <= reg_rdata;
                pop_pend <= pop_start;
                if (wbs_we_i && ofs == OFS_RDPTR) rd_ptr <= wbs_dat_i[PTR_W-1:0];
                if (wbs_we_i && ofs == OFS_RDPTR) underflow <= 1'b0;
                if (wbs_we_i && ofs == OFS_THRESH) thresh <= wbs_dat_i[PTR_W-1:0];
                if (pop_rd && empty) underflow <= 1'b1;
            end
            if (state_q == ST_CAP && rd_valid) wbs_dat_o <= rd_data;
            // the pop is committed only on the ack edge so a reset mid-access leaves no trace
            if (state_q == ST_ACK && pop_pend) begin
                rd_ptr <= rd_ptr + 1'b1;
                pop_pend <= 1'b0;
            end
            irq_q <= thresh != '0 && level >= thresh;
        end
    end

    sample_sram_rdport u_rdport (
        .clk         (wb_clk_i),
        .rst_n       (wb_rst_ni),
        .req         (mem_req),
        .bank        (req_bank),
        .word        (req_word),
        .mem_data0_i (mem_data0_i),
        .mem_data1_i (mem_data1_i),
        .mem_renb_o  (mem_renb_o),
        .mem_raddr_o (mem_raddr_o),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid)
    );

    assign wbs_ack_o = state_q == ST_ACK;
    assign rd_ptr_o = rd_ptr;
    assign empty_o = empty;
    assign irq_o = irq_q;
endmodule

// File: tb/tb_sample_buf_reader.sv
// tb_sample_buf_reader: directed self-checking bench for sample_buf_reader with a registered-output SRAM model.
`timescale 1ns/1ps
module tb_sample_buf_reader;
    localparam logic [31:0] BASE = 32'h3000_0000;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0] sel = 4'hF;
    logic [31:0] adr = '0, dat_w = '0;
    logic ack;
    logic [31:0] dat_r;
    logic [11:0] wr_ptr = '0;
    logic [11:0] rd_ptr;
    logic [1:0] renb;
    logic [9:0] raddr;
    logic [31:0] d0 = '0, d1 = '0;
    logic empty, irq;
    logic [31:0] mem0 [1024];
    logic [31:0] mem1 [1024];
    int checks = 0;
    int errors = 0;

    sample_buf_reader dut (
        .wb_clk_i    (clk),
        .wb_rst_ni   (rst_n),
        .wbs_cyc_i   (cyc),
        .wbs_stb_i   (stb),
        .wbs_we_i    (we),
        .wbs_sel_i   (sel),
        .wbs_adr_i   (adr),
        .wbs_dat_i   (dat_w),
        .wbs_ack_o   (ack),
        .wbs_dat_o   (dat_r),
        .wr_ptr_i    (wr_ptr),
        .rd_ptr_o    (rd_ptr),
        .mem_renb_o  (renb),
        .mem_raddr_o (raddr),
        .mem_data0_i (d0),
        .mem_data1_i (d1),
        .empty_o     (empty),
        .irq_o       (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!renb[0]) d0 <= mem0[raddr];
        if (!renb[1]) d1 <= mem1[raddr];
    end

    task automatic wb_xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                           output logic [31:0] rdata, output int lat, output logic [1:0] renb_seen);
        logic done;
        @(posedge clk);
        #1;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d;
        lat = -1; rdata = '0; renb_seen = 2'b11; done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (!done) begin
                @(negedge clk);
                if (renb !== 2'b11) renb_seen = renb;
                if (ack === 1'b1) begin
                    rdata = dat_r;
                    lat = i;
                    done = 1'b1;
                end
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] r;
        int lat;
        logic [1:0] rs;
        rst_n = 1'b0;
        wr_ptr = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b exp 0", ack); end
        checks++; if (dat_r !== 32'h0) begin errors++; $display("FAIL reset_dat got %h exp 0", dat_r); end
        checks++; if (renb !== 2'b11) begin errors++; $display("FAIL reset_renb got %b exp 11", renb); end
        checks++; if (raddr !== 10'h0) begin errors++; $display("FAIL reset_raddr got %h exp 0", raddr); end
        checks++; if (rd_ptr !== 12'h0) begin errors++; $display("FAIL reset_rdptr got %h exp 0", rd_ptr); end
        checks++; if (irq !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL reset_irq_empty got %b%b exp 01", irq, empty); end
        rst_n = 1'b1;
        wb_xfer(BASE + 32'h4, 1'b0, '0, r, lat, rs);
        checks++; if (r !== 32'h0000_1000) begin errors++; $display("FAIL reset_status got %h exp 00001000", r); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL reset_status_lat got %0d exp 1", lat); end
        checks++; if (rs !== 2'b11) begin errors++; $display("FAIL reset_status_renb got %b exp 11", rs); end
    endtask

    task automatic test_pop;
        logic [31:0] r;
        int lat;
        logic [1:0] rs;
        logic [31:0] exp_d [3];
        exp_d[0] = 32'hA0; exp_d[1] = 32'hA1; exp_d[2] = 32'hA2;
        for (int i = 0; i < 3; i++) mem0[i] = exp_d[i];
        wr_ptr = 12'd3;
        for (int i = 0; i < 3; i++) begin
            wb_xfer(BASE, 1'b0, '0, r, lat, rs);
            checks++; if (r !== exp_d[i]) begin errors++; $display("FAIL pop%0d_data got %h exp %h", i, r, exp_d[i]); end
            checks++; if (lat !== 3) begin errors++; $display("FAIL pop%0d_lat got %0d exp 3", i, lat); end
            checks++; if (rs !== 2'b10) begin errors++; $display("FAIL pop%0d_renb got %b exp 10", i, rs); end
        end
        @(negedge clk);
        checks++; if (rd_ptr !== 12'd3 || empty !== 1'b1) begin errors++; $display("FAIL pop_rdptr got %h/%b exp 003/1", rd_ptr, empty); end
        wb_xfer(BASE, 1'b0, '0, r, lat, rs);
        checks++; if (r !== 32'h0 || lat !== 1 || rs !== 2'b11) begin errors++; $display("FAIL pop_empty got %h lat %0d renb %b exp 0 lat 1 renb 11", r, lat, rs); end
        wb_xfer(BASE + 32'h4, 1'b0, '0, r, lat, rs);
        checks++; if (r !== 32'h0000_3000) begin errors++; $display("FAIL underflow_status got %h exp 00003000", r); end
        checks++; if (rd_ptr !== 12'd3) begin errors++; $display("FAIL underflow_rdptr got %h exp 003", rd_ptr); end
    endtask

    task automatic test_bank_cross;
        logic [31:0] r;
        int lat;
        logic [1:0] rs;
        wb_xfer(BASE + 32'h8, 1'b1, 32'h3FF, r, lat, rs);
        checks++; if (lat !== 1) begin errors++; $display("FAIL rdptr_wr_lat got %0d exp 1", lat); end
        mem0[1023] = 32'h11;
        mem1[0] = 32'h22;
        wr_ptr = 12'h401;
        wb_xfer(BASE, 1'b0, '0, r, lat, rs);
        checks++; if (r !== 32'h11 || rs !== 2'b10) begin errors++; $display("FAIL cross_pop0 got %h renb %b exp 11 renb 10", r, rs); end
        wb_xfer(BASE, 1'b0, '0, r, lat, rs);
        checks++; if (r !== 32'h22 || rs !== 2'b01) begin errors++; $display("FAIL cross_pop1 got %h renb %b exp 22 renb 01", r, rs); end
        wb_xfer(BASE + 32'h8, 1'b0, '0, r, lat, rs);
        checks++; if (r !== 32'h401) begin errors++; $display("FAIL cross_rdptr got %h exp 401", r); end
    endtask

    task automatic test_wrap;
        logic [31:0] r;
        int lat;
        logic [1:0] rs;
        wb_xfer(BASE + 32'h8, 1'b1, 32'hFFF, r, lat, rs);
        mem1[1023] = 32'h55;
        wr_ptr = 12'h000;
        wb_xfer(BASE + 32'h4, 1'b0, '0, r, lat, rs);
        checks++; if (r !== 32'h0000_0001) begin errors++; $display("FAIL wrap_status got %h exp 00000001", r); end
        wb_xfer(BASE, 1'b0, '0, r, lat, rs);
        checks++; if (r !== 32'h55 || rs !== 2'b01) begin errors++; $display("FAIL wrap_pop got %h renb %b exp 55 renb 01", r, rs); end
        @(negedge clk);
        checks++; if (rd_ptr !== 12'h000 || empty !== 1'b1) begin errors++; $display("FAIL wrap_rdptr got %h/%b exp 000/1", rd_ptr, empty); end
    endtask

    task automatic test_irq;
        logic [31:0] r;
        int lat;
        logic [1:0] rs;
        mem0[0] = 32'h77;
        wb_xfer(BASE + 32'hC, 1'b1, 32'h4, r, lat, rs);
        wb_xfer(BASE + 32'hC, 1'b0, '0, r, lat, rs);
        checks++; if (r !== 32'h4) begin errors++; $display("FAIL thresh_rd got %h exp 4", r); end
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1 wr_ptr = 12'(k);
            @(negedge clk);
            checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_low_lvl%0d got %b exp 0", k, irq); end
        end
        @(negedge clk);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_rise got %b exp 1", irq); end
        wb_xfer(BASE, 1'b0, '0, r, lat, rs);
        checks++; if (r !== 32'h77) begin errors++; $display("FAIL irq_pop got %h exp 77", r); end
        @(negedge clk);
        checks++; if (rd_ptr !== 12'd1 || irq !== 1'b1) begin errors++; $display("FAIL irq_hold got %h/%b exp 001/1", rd_ptr, irq); end
        @(negedge clk);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_fall got %b exp 0", irq); end
    endtask

    task automatic test_reset_mid;
        logic seen;
        @(posedge clk);
        #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE;
        @(posedge clk);
        @(negedge clk);
        checks++; if (renb !== 2'b10 || raddr !== 10'd1) begin errors++; $display("FAIL mid_mem got %b/%h exp 10/001", renb, raddr); end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (ack !== 1'b0 || renb !== 2'b11 || raddr !== 10'h0) begin errors++; $display("FAIL mid_rst_bus got %b %b %h exp 0 11 000", ack, renb, raddr); end
        checks++; if (rd_ptr !== 12'h0 || dat_r !== 32'h0) begin errors++; $display("FAIL mid_rst_regs got %h %h exp 000 0", rd_ptr, dat_r); end
        cyc = 1'b0; stb = 1'b0;
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (ack !== 1'b0 || irq !== 1'b0 || renb !== 2'b11) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_rst_after got 1 exp 0"); end
    endtask

    task automatic test_back_to_back;
        int n;
        int ack_cyc [2];
        logic [31:0] ack_dat [2];
        mem0[0] = 32'hC0;
        mem0[1] = 32'hC1;
        n = 0;
        ack_cyc[0] = -1; ack_cyc[1] = -1;
        ack_dat[0] = '0; ack_dat[1] = '0;
        @(posedge clk);
        #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            if (ack === 1'b1) begin
                if (n < 2) begin ack_cyc[n] = c; ack_dat[n] = dat_r; end
                n++;
                if (n == 2) begin cyc = 1'b0; stb = 1'b0; end
            end
        end
        cyc = 1'b0; stb = 1'b0;
        checks++; if (n !== 2 || ack_cyc[0] !== 3 || ack_cyc[1] !== 7) begin errors++; $display("FAIL b2b_timing got n=%0d at %0d,%0d exp 2 at 3,7", n, ack_cyc[0], ack_cyc[1]); end
        checks++; if (ack_dat[0] !== 32'hC0 || ack_dat[1] !== 32'hC1) begin errors++; $display("FAIL b2b_data got %h,%h exp c0,c1", ack_dat[0], ack_dat[1]); end
        checks++; if (rd_ptr !== 12'd2) begin errors++; $display("FAIL b2b_rdptr got %h exp 002", rd_ptr); end
    endtask

    task automatic test_window;
        logic [31:0] r;
        int lat;
        logic [1:0] rs;
        mem1[1] = 32'hB1;
        wb_xfer(BASE + 32'h3004, 1'b0, '0, r, lat, rs);
`ifdef SAMPLE_READER_WINDOW_EN
        checks++; if (r !== 32'hB1 || lat !== 3 || rs !== 2'b01) begin errors++; $display("FAIL window_rd got %h lat %0d renb %b exp b1 lat 3 renb 01", r, lat, rs); end
`else
        checks++; if (r !== 32'h0 || lat !== 1 || rs !== 2'b11) begin errors++; $display("FAIL window_rd got %h lat %0d renb %b exp 0 lat 1 renb 11", r, lat, rs); end
`endif
        wb_xfer(BASE + 32'h3004, 1'b1, 32'hDEAD, r, lat, rs);
        checks++; if (lat !== 1 || rs !== 2'b11 || mem1[1] !== 32'hB1) begin errors++; $display("FAIL window_wr got lat %0d renb %b exp lat 1 renb 11", lat, rs); end
        checks++; if (rd_ptr !== 12'd2) begin errors++; $display("FAIL window_rdptr got %h exp 002", rd_ptr); end
    endtask

    task automatic test_misc;
        logic [31:0] r;
        int lat;
        logic [1:0] rs;
        logic seen;
        seen = 1'b0;
        @(posedge clk);
        #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h4000_0000;
        repeat (5) begin
            @(negedge clk);
            if (ack !== 1'b0) seen = 1'b1;
        end
        cyc = 1'b0; stb = 1'b0;
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL nodecode_ack got 1 exp 0"); end
        wb_xfer(BASE + 32'h10, 1'b0, '0, r, lat, rs);
        checks++; if (r !== 32'h0 || lat !== 1) begin errors++; $display("FAIL other_ofs got %h lat %0d exp 0 lat 1", r, lat); end
        wb_xfer(BASE + 32'h4, 1'b1, 32'hFFF, r, lat, rs);
        wb_xfer(BASE + 32'h8, 1'b0, '0, r, lat, rs);
        checks++; if (r !== 32'h2) begin errors++; $display("FAIL ro_write got rdptr %h exp 2", r); end
        wb_xfer(BASE + 32'h4, 1'b0, '0, r, lat, rs);
        checks++; if (r !== 32'h0000_0002) begin errors++; $display("FAIL status_lvl2 got %h exp 00000002", r); end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem0[i] = 32'h0;
            mem1[i] = 32'h0;
        end
        test_reset;
        test_pop;
        test_bank_cross;
        test_wrap;
        test_irq;
        test_reset_mid;
        test_back_to_back;
        test_window;
        test_misc;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
